// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS controllers.
//   - opcode / funct / rt codes of the supported ISA subset
//   - 5-bit ALU operation encodings
//   - datapath select encodings (pc_src, reg_dst, wb_sel, alu_src_a, alu_src_b)
//   - multi-cycle FSM state enum and the packed control-word struct
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // REGIMM rt field selecting bgez
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    // R-type funct codes
    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_SRA    = 6'h03;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MUL    = 6'h18;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_SUBU   = 6'h23;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_NOR    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    // ALU operations
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_ADDU  = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SUBU  = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4;
    localparam logic [4:0] ALU_OR    = 5'd5;
    localparam logic [4:0] ALU_NOR   = 5'd6;
    localparam logic [4:0] ALU_SLT   = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_LUI   = 5'd11;
    localparam logic [4:0] ALU_MUL   = 5'd12;

    // pc_src
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    // reg_dst
    localparam logic [1:0] RD_RT     = 2'd0;
    localparam logic [1:0] RD_RD     = 2'd1;
    localparam logic [1:0] RD_RA     = 2'd2;

    // wb_sel
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] WB_MUL    = 2'd3;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    // alu_src_b
    localparam logic [2:0] SRCB_RT     = 3'd0;
    localparam logic [2:0] SRCB_FOUR   = 3'd1;
    localparam logic [2:0] SRCB_IMM    = 3'd2;
    localparam logic [2:0] SRCB_IMM_SH = 3'd3;
    localparam logic [2:0] SRCB_ZERO   = 3'd4;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH,
        S_JUMP, S_JR, S_MUL_WAIT, S_TRAP
    } state_e;

    // One cycle's worth of controller outputs.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic       ext_zero;
        logic [4:0] alu_op;
        logic       mul_start;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

    // R-type functs that take the EXEC_R / WB_R path
    function automatic logic is_rtype_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_NOR, FN_SLT, FN_SLL, FN_SRL, FN_SRA: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   master: the controller (drives selects/strobes, reads instr/flags/handshakes)
//   slave : the datapath side (drives instr, ALU flags, mem_ready, mul_done)
interface mips_multicycle_ctrl_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_neg;
    logic        mem_ready;
    logic        mul_done;

    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic        ext_zero;
    logic [4:0]  alu_op;
    logic        mul_start;
    logic        instr_done;
    logic        illegal;

    modport master (
        input  instr, alu_zero, alu_neg, mem_ready, mul_done,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b,
               ext_zero, alu_op, mul_start, instr_done, illegal
    );

    modport slave (
        output instr, alu_zero, alu_neg, mem_ready, mul_done,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b,
               ext_zero, alu_op, mul_start, instr_done, illegal
    );
endinterface

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: combinational opcode/funct -> ALU operation map.
//   i_opcode, i_funct : instruction fields
//   o_alu_op          : 5-bit ALU operation
//   o_ext_zero        : immediate is zero-extended (andi/ori)
// Opcodes with no ALU meaning of their own (loads, stores, jumps) map to ADD.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [4:0] o_alu_op,
    output logic       o_ext_zero
);

    always_comb begin
        o_alu_op   = ALU_ADD;
        o_ext_zero = 1'b0;
        if (i_opcode == OP_RTYPE) begin
            case (i_funct)
                FN_ADD:  o_alu_op = ALU_ADD;
                FN_ADDU: o_alu_op = ALU_ADDU;
                FN_SUB:  o_alu_op = ALU_SUB;
                FN_SUBU: o_alu_op = ALU_SUBU;
                FN_AND:  o_alu_op = ALU_AND;
                FN_OR:   o_alu_op = ALU_OR;
                FN_NOR:  o_alu_op = ALU_NOR;
                FN_SLT:  o_alu_op = ALU_SLT;
                FN_SLL:  o_alu_op = ALU_SLL;
                FN_SRL:  o_alu_op = ALU_SRL;
                FN_SRA:  o_alu_op = ALU_SRA;
                FN_MUL:  o_alu_op = ALU_MUL;
                default: o_alu_op = ALU_ADD;
            endcase
        end else begin
            case (i_opcode)
                OP_ADDI:  o_alu_op = ALU_ADD;
                OP_ADDIU: o_alu_op = ALU_ADDU;
                OP_SLTI:  o_alu_op = ALU_SLT;
                OP_LUI:   o_alu_op = ALU_LUI;
                OP_ANDI: begin
                    o_alu_op   = ALU_AND;
                    o_ext_zero = 1'b1;
                end
                OP_ORI: begin
                    o_alu_op   = ALU_OR;
                    o_ext_zero = 1'b1;
                end
                default:  o_alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : controller side of mips_multicycle_ctrl_if
//                in : instr, alu_zero, alu_neg, mem_ready, mul_done
//                out: memory strobes, datapath selects, alu_op, mul_start,
//                     instr_done, illegal
// Outputs are decoded from the registered state plus instr and handshakes.
// MUL_MAX_CYCLES bounds the wait for mul_done before trapping.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_MAX_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    localparam int               CNT_W    = $clog2(MUL_MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_MAX_CYCLES - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_mul_cnt;
    ctrl_t            w_ctrl;
    logic             w_taken;

    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [4:0]       w_rt;
    logic [4:0]       w_dec_alu_op;
    logic             w_dec_ext_zero;
    logic             w_unused;

    assign w_opcode = bus.instr[31:26];
    assign w_rt     = bus.instr[20:16];
    assign w_funct  = bus.instr[5:0];
    // rs/rd/shamt/imm are datapath concerns, not control
    assign w_unused = ^{bus.instr[25:21], bus.instr[15:6]};

    mips_alu_decode u_alu_decode (
        .i_opcode   (w_opcode),
        .i_funct    (w_funct),
        .o_alu_op   (w_dec_alu_op),
        .o_ext_zero (w_dec_ext_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_mul_cnt <= '0;
        end else begin
            r_state <= w_next;
            // counts MUL_WAIT cycles without mul_done; zero everywhere else,
            // so a zero count also marks the first MUL_WAIT cycle
            if (r_state == S_MUL_WAIT && !bus.mul_done)
                r_mul_cnt <= r_mul_cnt + CNT_W'(1);
            else
                r_mul_cnt <= '0;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ctrl  = '0;
        w_taken = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.iord      = 1'b0;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = PC_ALU;
                    w_next          = S_DECODE;
                end
            end

            S_DECODE: begin
                // speculative branch target into ALUOut
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                w_ctrl.alu_op    = ALU_ADD;
                case (w_opcode)
                    OP_RTYPE: begin
                        if (is_rtype_alu(w_funct))  w_next = S_EXEC_R;
                        else if (w_funct == FN_JR)  w_next = S_JR;
                        else if (w_funct == FN_MUL) w_next = S_MUL_WAIT;
                        else                        w_next = S_TRAP;
                    end
                    OP_ANDI, OP_ORI, OP_SLTI,
                    OP_ADDI, OP_ADDIU, OP_LUI:      w_next = S_EXEC_I;
                    OP_LW, OP_SW:                   w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGTZ:        w_next = S_BRANCH;
                    OP_REGIMM:                      w_next = (w_rt == RT_BGEZ) ? S_BRANCH : S_TRAP;
                    OP_J, OP_JAL:                   w_next = S_JUMP;
                    default:                        w_next = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                w_ctrl.alu_src_a = is_shift(w_funct) ? SRCA_SHAMT : SRCA_RS;
                w_ctrl.alu_src_b = SRCB_RT;
                w_ctrl.alu_op    = w_dec_alu_op;
                w_next           = S_WB_R;
            end

            S_WB_R: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = RD_RD;
                w_ctrl.wb_sel     = WB_ALUOUT;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.ext_zero  = w_dec_ext_zero;
                w_ctrl.alu_op    = w_dec_alu_op;
                w_next           = S_WB_I;
            end

            S_WB_I: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = RD_RT;
                w_ctrl.wb_sel     = WB_ALUOUT;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_RS;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_next           = (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (bus.mem_ready) w_next = S_WB_MEM;
            end

            S_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = RD_RT;
                w_ctrl.wb_sel     = WB_MDR;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_we  = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_ctrl.instr_done = 1'b1;
                    w_next            = S_FETCH;
                end
            end

            S_BRANCH: begin
                w_ctrl.alu_src_a = SRCA_RS;
                w_ctrl.alu_op    = ALU_SUB;
                // bgez/bgtz compare rs against zero
                w_ctrl.alu_src_b = (w_opcode == OP_BEQ || w_opcode == OP_BNE) ? SRCB_RT : SRCB_ZERO;
                case (w_opcode)
                    OP_BEQ:    w_taken = bus.alu_zero;
                    OP_BNE:    w_taken = !bus.alu_zero;
                    OP_REGIMM: w_taken = !bus.alu_neg;
                    OP_BGTZ:   w_taken = !bus.alu_neg && !bus.alu_zero;
                    default:   w_taken = 1'b0;
                endcase
                if (w_taken) begin
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = PC_ALUOUT;
                end
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PC_JUMP;
                if (w_opcode == OP_JAL) begin
                    // PC already holds the return address (+4 done in FETCH)
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.reg_dst   = RD_RA;
                    w_ctrl.wb_sel    = WB_PC;
                end
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_JR: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_src     = PC_RS;
                w_ctrl.instr_done = 1'b1;
                w_next            = S_FETCH;
            end

            S_MUL_WAIT: begin
                w_ctrl.mul_start = (r_mul_cnt == '0);
                // completion takes priority over the watchdog
                if (bus.mul_done) begin
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.reg_dst    = RD_RD;
                    w_ctrl.wb_sel     = WB_MUL;
                    w_ctrl.instr_done = 1'b1;
                    w_next            = S_FETCH;
                end else if (r_mul_cnt == CNT_LAST) begin
                    w_next = S_TRAP;
                end
            end

            S_TRAP: begin
                w_ctrl.illegal = 1'b1;
            end

            default: w_next = S_FETCH;
        endcase

        // In the reset cycle only the FETCH selects are shown; no strobe or
        // write escapes from whatever state was interrupted.
        if (reset) begin
            w_ctrl           = '0;
            w_ctrl.alu_src_a = SRCA_PC;
            w_ctrl.alu_src_b = SRCB_FOUR;
            w_ctrl.alu_op    = ALU_ADD;
            w_next           = S_FETCH;
        end
    end

    assign bus.mem_req    = w_ctrl.mem_req;
    assign bus.mem_we     = w_ctrl.mem_we;
    assign bus.iord       = w_ctrl.iord;
    assign bus.ir_write   = w_ctrl.ir_write;
    assign bus.pc_write   = w_ctrl.pc_write;
    assign bus.pc_src     = w_ctrl.pc_src;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.wb_sel     = w_ctrl.wb_sel;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.ext_zero   = w_ctrl.ext_zero;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.mul_start  = w_ctrl.mul_start;
    assign bus.instr_done = w_ctrl.instr_done;
    assign bus.illegal    = w_ctrl.illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mips_multicycle_ctrl;

    localparam logic [31:0] I_ADD   = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_SUB   = 32'h0022_1822; // sub  $3,$1,$2
    localparam logic [31:0] I_SLL   = 32'h0002_1900; // sll  $3,$2,4
    localparam logic [31:0] I_ORI   = 32'h3422_0005; // ori  $2,$1,5
    localparam logic [31:0] I_ADDI  = 32'h2022_0005; // addi $2,$1,5
    localparam logic [31:0] I_LW    = 32'h8C22_0004; // lw   $2,4($1)
    localparam logic [31:0] I_SW    = 32'hAC22_0004; // sw   $2,4($1)
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_BNE   = 32'h1422_0003;
    localparam logic [31:0] I_BGEZ  = 32'h0421_0003;
    localparam logic [31:0] I_BLTZ  = 32'h0420_0003; // REGIMM rt=0: unsupported
    localparam logic [31:0] I_BGTZ  = 32'h1C20_0003;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_MUL   = 32'h0022_1818;
    localparam logic [31:0] I_BAD   = 32'hFC00_0000; // opcode 0x3F

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MUL_MAX_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] w, input int waits);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            chk("fetch_wait_req", bus.mem_req, 1);
            chk("fetch_wait_irw", bus.ir_write, 0);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("fetch_irw", bus.ir_write, 1);
        chk("fetch_pcw", bus.pc_write, 1);
        chk("fetch_srcb", bus.alu_src_b, 1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.instr     = w;
    endtask

    task automatic decode();
        #1;
        chk("dec_srcb", bus.alu_src_b, 3);
        chk("dec_pcw", bus.pc_write, 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_rst_req"}, bus.mem_req, 0);
        chk({tag, "_rst_we"}, bus.mem_we, 0);
        chk({tag, "_rst_rw"}, bus.reg_write, 0);
        chk({tag, "_rst_done"}, bus.instr_done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, "_post_ill"}, bus.illegal, 0);
        chk({tag, "_post_req"}, bus.mem_req, 1);
        chk({tag, "_post_iord"}, bus.iord, 0);
        @(negedge clk);
    endtask

    task automatic run_r(input string tag, input logic [31:0] w, input logic [4:0] op,
                         input logic [1:0] srca);
        fetch(w, 0);
        decode();
        #1;
        chk({tag, "_srca"}, bus.alu_src_a, srca);
        chk({tag, "_srcb"}, bus.alu_src_b, 0);
        chk({tag, "_op"}, bus.alu_op, op);
        chk({tag, "_ex_rw"}, bus.reg_write, 0);
        @(negedge clk);
        #1;
        chk({tag, "_rw"}, bus.reg_write, 1);
        chk({tag, "_dst"}, bus.reg_dst, 1);
        chk({tag, "_wb"}, bus.wb_sel, 0);
        chk({tag, "_done"}, bus.instr_done, 1);
        @(negedge clk);
    endtask

    task automatic run_i(input string tag, input logic [31:0] w, input logic [4:0] op,
                         input logic ez);
        fetch(w, 0);
        decode();
        #1;
        chk({tag, "_srca"}, bus.alu_src_a, 1);
        chk({tag, "_srcb"}, bus.alu_src_b, 2);
        chk({tag, "_ez"}, bus.ext_zero, ez);
        chk({tag, "_op"}, bus.alu_op, op);
        @(negedge clk);
        #1;
        chk({tag, "_rw"}, bus.reg_write, 1);
        chk({tag, "_dst"}, bus.reg_dst, 0);
        chk({tag, "_done"}, bus.instr_done, 1);
        @(negedge clk);
    endtask

    task automatic run_b(input string tag, input logic [31:0] w, input logic z, input logic n,
                         input logic taken, input logic [2:0] srcb);
        fetch(w, 0);
        decode();
        bus.alu_zero = z;
        bus.alu_neg  = n;
        #1;
        chk({tag, "_pcw"}, bus.pc_write, taken);
        chk({tag, "_pcsrc"}, bus.pc_src, taken ? 1 : 0);
        chk({tag, "_srcb"}, bus.alu_src_b, srcb);
        chk({tag, "_op"}, bus.alu_op, 2);
        chk({tag, "_done"}, bus.instr_done, 1);
        @(negedge clk);
        bus.alu_zero = 1'b0;
        bus.alu_neg  = 1'b0;
    endtask

    task automatic run_j(input string tag, input logic [31:0] w, input logic [1:0] src,
                         input logic link);
        fetch(w, 0);
        decode();
        #1;
        chk({tag, "_pcw"}, bus.pc_write, 1);
        chk({tag, "_pcsrc"}, bus.pc_src, src);
        chk({tag, "_rw"}, bus.reg_write, link);
        chk({tag, "_dst"}, bus.reg_dst, link ? 2 : 0);
        chk({tag, "_wb"}, bus.wb_sel, link ? 2 : 0);
        chk({tag, "_done"}, bus.instr_done, 1);
        @(negedge clk);
    endtask

    // mem_ready tied high; cycles from FETCH entry through the retire pulse
    task automatic timed(input string tag, input logic [31:0] w, input int exp_n);
        int   n = 0;
        logic d = 1'b0;
        bus.instr     = w;
        bus.mem_ready = 1'b1;
        while (!d && n < 64) begin
            #1;
            d = bus.instr_done;
            n++;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        chk({tag, "_cycles"}, n, exp_n);
    endtask

    task automatic trap_case(input string tag, input logic [31:0] w);
        fetch(w, 0);
        decode();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({tag, "_ill"}, bus.illegal, 1);
            chk({tag, "_req"}, bus.mem_req, 0);
            chk({tag, "_irw"}, bus.ir_write, 0);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        do_reset(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int   n;
        int   starts;
        logic d;

        n_chk         = 0;
        n_fail        = 0;
        clk           = 1'b0;
        reset         = 1'b1;
        bus.instr     = '0;
        bus.alu_zero  = 1'b0;
        bus.alu_neg   = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mul_done  = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_ill", bus.illegal, 0);
        chk("rst_srcb", bus.alu_src_b, 1);
        chk("rst_pcw", bus.pc_write, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req", bus.mem_req, 1);
        chk("first_irw", bus.ir_write, 0);
        @(negedge clk);

        // ALU instructions
        run_r("add", I_ADD, 5'd0, 2'd1);
        run_r("sub", I_SUB, 5'd2, 2'd1);
        run_r("sll", I_SLL, 5'd8, 2'd2);
        run_i("ori", I_ORI, 5'd5, 1'b1);
        run_i("addi", I_ADDI, 5'd0, 1'b0);

        // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles
        fetch(I_LW, 2);
        decode();
        #1;
        chk("lw_addr_req", bus.mem_req, 0);
        chk("lw_addr_srca", bus.alu_src_a, 1);
        chk("lw_addr_srcb", bus.alu_src_b, 2);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lw_wait_req", bus.mem_req, 1);
            chk("lw_wait_iord", bus.iord, 1);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_rd_req", bus.mem_req, 1);
        chk("lw_rd_rw", bus.reg_write, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("lw_wb_rw", bus.reg_write, 1);
        chk("lw_wb_dst", bus.reg_dst, 0);
        chk("lw_wb_sel", bus.wb_sel, 1);
        chk("lw_wb_done", bus.instr_done, 1);
        @(negedge clk);

        // branches over every flag combination of interest
        run_b("beq_t", I_BEQ, 1'b1, 1'b0, 1'b1, 3'd0);
        run_b("beq_n", I_BEQ, 1'b0, 1'b0, 1'b0, 3'd0);
        run_b("bne_t", I_BNE, 1'b0, 1'b1, 1'b1, 3'd0);
        run_b("bne_n", I_BNE, 1'b1, 1'b0, 1'b0, 3'd0);
        run_b("bgez_t0", I_BGEZ, 1'b1, 1'b0, 1'b1, 3'd4);
        run_b("bgez_n", I_BGEZ, 1'b0, 1'b1, 1'b0, 3'd4);
        run_b("bgtz_t", I_BGTZ, 1'b0, 1'b0, 1'b1, 3'd4);
        run_b("bgtz_z", I_BGTZ, 1'b1, 1'b0, 1'b0, 3'd4);
        run_b("bgtz_n", I_BGTZ, 1'b0, 1'b1, 1'b0, 3'd4);

        // jumps
        run_j("jal", I_JAL, 2'd2, 1'b1);
        run_j("j", I_J, 2'd2, 1'b0);
        run_j("jr", I_JR, 2'd3, 1'b0);

        // latencies with mem_ready tied high
        timed("t_add", I_ADD, 4);
        timed("t_ori", I_ORI, 4);
        timed("t_lw", I_LW, 5);
        timed("t_sw", I_SW, 4);
        timed("t_beq", I_BEQ, 3);
        timed("t_j", I_J, 3);
        timed("t_jal", I_JAL, 3);
        timed("t_jr", I_JR, 3);
        bus.mul_done = 1'b1;
        timed("t_mul0", I_MUL, 3);
        bus.mul_done = 1'b0;

        // mul completing on the 6th MUL_WAIT cycle
        fetch(I_MUL, 0);
        decode();
        starts = 0;
        for (int k = 0; k <= 5; k++) begin
            bus.mul_done = (k == 5);
            #1;
            starts += int'(bus.mul_start);
            if (k < 5) chk("mul_wait_done", bus.instr_done, 0);
            @(negedge clk);
        end
        // last sampled cycle was the completion cycle; re-sample it is gone,
        // so check completion outputs via a second run below
        chk("mul_starts", starts, 1);
        bus.mul_done = 1'b0;

        fetch(I_MUL, 0);
        decode();
        for (int k = 0; k < 5; k++) @(negedge clk);
        bus.mul_done = 1'b1;
        #1;
        chk("mul_rw", bus.reg_write, 1);
        chk("mul_dst", bus.reg_dst, 1);
        chk("mul_wb", bus.wb_sel, 3);
        chk("mul_done_pulse", bus.instr_done, 1);
        chk("mul_start_late", bus.mul_start, 0);
        @(negedge clk);
        bus.mul_done = 1'b0;

        // mul_done together with the watchdog limit: completion wins
        fetch(I_MUL, 0);
        decode();
        for (int k = 0; k < 31; k++) @(negedge clk);
        bus.mul_done = 1'b1;
        #1;
        chk("mul_lim_done", bus.instr_done, 1);
        chk("mul_lim_ill", bus.illegal, 0);
        @(negedge clk);
        bus.mul_done = 1'b0;
        #1;
        chk("mul_lim_fetch", bus.mem_req, 1);
        chk("mul_lim_ill2", bus.illegal, 0);
        @(negedge clk);

        // mul_done never arrives: trap after 32 waiting cycles
        fetch(I_MUL, 0);
        decode();
        n      = 0;
        d      = 1'b0;
        starts = 0;
        while (!d && n < 40) begin
            #1;
            starts += int'(bus.mul_start);
            d = bus.illegal;
            if (!d) n++;
            @(negedge clk);
        end
        chk("wdog_cycles", n, 32);
        chk("wdog_starts", starts, 1);
        bus.mem_ready = 1'b1;
        #1;
        chk("wdog_sticky", bus.illegal, 1);
        chk("wdog_req", bus.mem_req, 0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        do_reset("wdog");

        // illegal encodings
        trap_case("op3f", I_BAD);
        trap_case("bltz", I_BLTZ);

        // reset while sw waits for memory
        fetch(I_SW, 0);
        decode();
        @(negedge clk);
        #1;
        chk("sw_wait_we", bus.mem_we, 1);
        chk("sw_wait_iord", bus.iord, 1);
        chk("sw_wait_done", bus.instr_done, 0);
        @(negedge clk);
        do_reset("sw_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
